strassen_tile_reader: RTL and testbench
=======================================

# strassen_tile_reader

- Unloads one DIM×DIM matrix tile from the Strassen datapath's enable-gated register bank and streams its elements out one per beat under a valid/ready handshake.
- A tile is captured in parallel into an internal bank of async-reset, enable-gated registers, then read out in row-major or column-major order.
- Sits between the sub-product/accumulate stage and the result sink, which accepts one scalar per beat.

## Interface
- WIDTH, 16, element width in bits
- DIM, 2, tile dimension; ELEMS = DIM*DIM elements; IDXW = max(1, $clog2(ELEMS))
- Clk  input  1  single clock, all state updates on rising edge
- Rst  input  1  asynchronous, active-high reset
- Load_valid  input  1  Tile_in holds a valid tile
- Load_ready  output  1  reader can capture a tile this cycle
- Tile_in  input  WIDTH*ELEMS  element k (row-major, k = r*DIM + c) at bits [k*WIDTH +: WIDTH]
- Abort  input  1  synchronous abandon of the current tile
- Out_data  output  WIDTH  current element
- Out_valid  output  1  Out_data/Out_idx/Out_last valid
- Out_ready  input  1  sink accepts the beat
- Out_idx  output  IDXW  row-major index of the current element
- Out_last  output  1  current beat is the final element of the tile

## Operation
- States:
  - IDLE: Load_ready=1, Out_valid=0.
  - STREAM: Load_ready=0, Out_valid=1.
- Capture: Load_valid && Load_ready on a rising edge loads all ELEMS elements into the bank, sets beat counter n=0 and moves to STREAM. The bank's enable is asserted only on this event.
- Beat n presents element ord(n):
  - Row-major: ord(n) = n.
  - Column-major: ord(n) = (n mod DIM)*DIM + n/DIM.
  - Out_idx = ord(n). Out_data = bank[ord(n)]. Out_last = (n == ELEMS-1).
- Transfer: a beat transfers on Out_valid && Out_ready.
  - If n < ELEMS-1, n increments.
  - If n == ELEMS-1, return to IDLE and set n=0.
- Stall: with Out_ready=0, Out_data, Out_idx and Out_last hold stable and Out_valid stays 1. No element is skipped or repeated.
- Tile_in and Load_valid are ignored in STREAM. The bank is not overwritten mid-stream.
- Abort in STREAM: next state IDLE, n=0. Abort wins over a simultaneous handshake, and that beat counts as not delivered. The bank keeps its contents.
- Abort in IDLE has priority over Load_valid: no capture occurs that cycle.
- Reset mid-stream: the bank clears to 0, state goes to IDLE and n=0. Any partial tile is discarded.

## Timing
- Reset values: Load_ready=1, Out_valid=0, Out_last=0, Out_idx=0, Out_data=0, bank all 0, state IDLE.
- Capture edge to first Out_valid: 1 cycle. Element 0 (or its column-major equivalent) is visible in the cycle after capture.
- Sink holding Out_ready=1: ELEMS consecutive beats, then 1 IDLE cycle.
  - Sustained throughput is one tile per ELEMS+1 cycles.
  - Load_ready is a registered state decode only, with no combinational path from Out_ready.
- Out_data, Out_idx and Out_last are a mux off registered state (bank and n). There is no combinational path from Load_valid or Tile_in to any output.
- Load_ready returns to 1 in the cycle after the last beat transfers or after Abort.

## Configuration
- STRASSEN_TILE_READER_COLMAJOR_EN
  - Defined: beats use column-major order.
  - Undefined: row-major order, ord(n) = n.
- Out_idx always reports the row-major index in both builds. Latency and throughput are identical in both builds.

## Test plan
All cases use WIDTH=16, DIM=2.

- Reset then load Tile_in={0x0004,0x0003,0x0002,0x0001} with Out_ready=1:
  - Beats 0x0001,0x0002,0x0003,0x0004 with Out_idx 0,1,2,3.
  - Out_last only on 0x0004.
  - Load_ready=0 for 4 cycles, then 1.
- Same tile built with STRASSEN_TILE_READER_COLMAJOR_EN:
  - Beats 0x0001,0x0003,0x0002,0x0004 with Out_idx 0,2,1,3.
- Out_ready toggling 1,0,0,1,0,1,1 with a random tile:
  - Each element is delivered exactly once, in order.
  - Outputs are stable while stalled.
  - Load_valid pulses with new data mid-stream are ignored.
- Abort asserted together with Out_ready on beat 2:
  - Only 2 beats are counted delivered.
  - Out_valid=0 and Load_ready=1 next cycle.
  - A new tile 0xAAAA.. then streams from index 0.
- Assert Rst asynchronously mid-beat 1:
  - Out_valid, Out_data and Out_idx go to 0 immediately.
  - Load_ready=1 after Rst deasserts.
  - No stale beat appears on the next load.
- Back-to-back tiles with Load_valid held high:
  - Exactly one IDLE cycle separates Out_last of tile A and beat 0 of tile B.

Source files
------------

// File: rtl/strassen_tile_reader.sv
`default_nettype none
// ============================================================================
//  Module      : strassen_tile_reader
//  Description : Captures one DIM x DIM tile into an enable-gated register
//                bank and streams its elements out one per beat under a
//                valid/ready handshake.
//  Options     : STRASSEN_TILE_READER_COLMAJOR_EN - defined: column-major
//                beat order; undefined: row-major beat order.
//  Revision    : 1.0 - initial release
// ============================================================================
module strassen_tile_reader #(
   parameter  int WIDTH = 16,
   parameter  int DIM   = 2,
   localparam int ELEMS = DIM * DIM,
   localparam int IDXW  = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Load_valid,
   output logic                   Load_ready,
   input  logic [WIDTH*ELEMS-1:0] Tile_in,
   input  logic                   Abort,
   output logic [WIDTH-1:0]       Out_data,
   output logic                   Out_valid,
   input  logic                   Out_ready,
   output logic [IDXW-1:0]        Out_idx,
   output logic                   Out_last
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   localparam logic [IDXW-1:0] c_last_beat = IDXW'(ELEMS - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [IDXW-1:0]  r_n;
   logic [IDXW-1:0]  w_n_next;
   logic [IDXW-1:0]  w_ord;
   logic             w_capture;
   logic [WIDTH-1:0] r_bank [ELEMS];

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Beat counter
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_n <= '0;
      end else begin
         r_n <= w_n_next;
      end
   end

   // Tile bank: written only on the capture handshake, cleared by reset
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int k = 0; k < ELEMS; k++) begin
            r_bank[k] <= '0;
         end
      end else if (w_capture) begin
         for (int k = 0; k < ELEMS; k++) begin
            r_bank[k] <= Tile_in[k*WIDTH +: WIDTH];
         end
      end
   end

   // Next state, counter update and handshake decode; Abort beats both
   // a pending capture and a pending transfer
   always_comb begin
      w_state_next = r_state;
      w_n_next     = r_n;
      w_capture    = 1'b0;
      Load_ready   = 1'b0;
      Out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            Load_ready = 1'b1;
            if (!Abort && Load_valid) begin
               w_capture    = 1'b1;
               w_state_next = ST_STREAM;
               w_n_next     = '0;
            end
         end
         ST_STREAM: begin
            Out_valid = 1'b1;
            if (Abort) begin
               w_state_next = ST_IDLE;
               w_n_next     = '0;
            end else if (Out_ready) begin
               if (r_n == c_last_beat) begin
                  w_state_next = ST_IDLE;
                  w_n_next     = '0;
               end else begin
                  w_n_next = r_n + 1'b1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_n_next     = '0;
         end
      endcase
   end

`ifdef STRASSEN_TILE_READER_COLMAJOR_EN
   // Beat n walks down column n/DIM: row-major index (n mod DIM)*DIM + n/DIM
   always_comb begin
      w_ord = IDXW'((int'(r_n) % DIM) * DIM + int'(r_n) / DIM);
   end
`else
   // Beat n is row-major element n
   always_comb begin
      w_ord = r_n;
   end
`endif

   // Outputs are a pure mux off registered bank and counter
   always_comb begin
      Out_idx  = w_ord;
      Out_data = r_bank[w_ord];
      Out_last = (r_state == ST_STREAM) && (r_n == c_last_beat);
   end

endmodule
`default_nettype wire

// File: tb/tb_strassen_tile_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_strassen_tile_reader
//  Description : Self-checking bench for strassen_tile_reader (WIDTH=16,
//                DIM=2) with a per-cycle behavioural model and directed tests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_strassen_tile_reader;

   localparam int WIDTH = 16;
   localparam int DIM   = 2;
   localparam int ELEMS = 4;

   logic                   Clk = 1'b0;
   logic                   Rst;
   logic                   Load_valid;
   logic                   Load_ready;
   logic [WIDTH*ELEMS-1:0] Tile_in;
   logic                   Abort;
   logic [WIDTH-1:0]       Out_data;
   logic                   Out_valid;
   logic                   Out_ready;
   logic [1:0]             Out_idx;
   logic                   Out_last;

   strassen_tile_reader #(.WIDTH(WIDTH), .DIM(DIM)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Load_valid (Load_valid),
      .Load_ready (Load_ready),
      .Tile_in    (Tile_in),
      .Abort      (Abort),
      .Out_data   (Out_data),
      .Out_valid  (Out_valid),
      .Out_ready  (Out_ready),
      .Out_idx    (Out_idx),
      .Out_last   (Out_last)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Beat order: list of row-major indices in delivery order
   int ord_q[ELEMS];
   initial begin
      int p = 0;
`ifdef STRASSEN_TILE_READER_COLMAJOR_EN
      for (int c = 0; c < DIM; c++)
         for (int r = 0; r < DIM; r++) begin
            ord_q[p] = r*DIM + c; p++;
         end
`else
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ord_q[p] = r*DIM + c; p++;
         end
`endif
   end

   // Model state
   bit          m_active = 1'b0;
   int          m_n = 0;
   logic [15:0] m_tile [ELEMS];

   // Delivered-beat log and counters
   logic [15:0] log_data[$];
   int          log_idx[$];
   bit          log_last[$];
   int          log_cyc[$];
   int          cyc = 0;
   int          lr_low = 0;

   bit          prev_hold = 1'b0;
   logic [15:0] prev_data;
   logic [1:0]  prev_idx;
   logic        prev_last;

   // Compare, log and advance the model once per cycle, mid-cycle
   always @(negedge Clk) begin
      cyc++;
      if (Rst) begin
         m_active = 1'b0;
         m_n      = 0;
      end
      if (!Load_ready) lr_low++;
      if (!Rst) begin
         check("flags", {Load_ready, Out_valid, Out_last},
               {!m_active, m_active, m_active && (m_n == ELEMS-1)});
         if (m_active)
            check("beat", {Out_idx, Out_data},
                  {2'(ord_q[m_n]), m_tile[ord_q[m_n]]});
         if (prev_hold)
            check("stall_stable", {Out_idx, Out_data, Out_last},
                  {prev_idx, prev_data, prev_last});
         if (Out_valid && Out_ready && !Abort) begin
            log_data.push_back(Out_data);
            log_idx.push_back(int'(Out_idx));
            log_last.push_back(Out_last);
            log_cyc.push_back(cyc);
         end
         prev_hold = Out_valid && !Out_ready && !Abort;
         prev_data = Out_data;
         prev_idx  = Out_idx;
         prev_last = Out_last;
         // advance using inputs that the next rising edge will sample
         if (!m_active) begin
            if (Load_valid && !Abort) begin
               for (int k = 0; k < ELEMS; k++) m_tile[k] = Tile_in[k*16 +: 16];
               m_active = 1'b1;
               m_n      = 0;
            end
         end else if (Abort) begin
            m_active = 1'b0;
            m_n      = 0;
         end else if (Out_ready) begin
            if (m_n == ELEMS-1) begin
               m_active = 1'b0;
               m_n      = 0;
            end else begin
               m_n++;
            end
         end
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_idx.delete();
      log_last.delete();
      log_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] t;
      logic [15:0] exp_d [ELEMS];
      int          exp_i [ELEMS];
      logic [3:0]  rdy_pat;
      logic [6:0]  pat;

      Rst = 1'b1; Load_valid = 1'b0; Tile_in = '0; Abort = 1'b0; Out_ready = 1'b1;
      #3;
      check("rst_load_ready", Load_ready, 1'b1);
      check("rst_out_valid", Out_valid, 1'b0);
      check("rst_out_last", Out_last, 1'b0);
      check("rst_out_idx", Out_idx, 2'd0);
      check("rst_out_data", Out_data, 16'h0);
      tick(); tick();
      Rst = 1'b0;
      tick();

      // Directed tile, sink always ready
`ifdef STRASSEN_TILE_READER_COLMAJOR_EN
      exp_d = '{16'h0001, 16'h0003, 16'h0002, 16'h0004};
      exp_i = '{0, 2, 1, 3};
`else
      exp_d = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
      exp_i = '{0, 1, 2, 3};
`endif
      clear_log(); lr_low = 0;
      Tile_in = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      Load_valid = 1'b1;
      tick();
      Load_valid = 1'b0;
      repeat (6) tick();
      check("t1_beats", log_data.size(), 4);
      check("t1_load_ready_low", lr_low, 4);
      check("t1_load_ready_after", Load_ready, 1'b1);
      if (log_data.size() == 4)
         for (int k = 0; k < 4; k++) begin
            check("t1_data", log_data[k], exp_d[k]);
            check("t1_idx", log_idx[k], exp_i[k]);
            check("t1_last", log_last[k], k == 3);
         end

      // Stalling sink, Load_valid pulses mid-stream
      clear_log();
      t = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      Tile_in = t; Load_valid = 1'b1;
      tick();
      pat = 7'b1101001;  // bit i is Out_ready on cycle i: 1,0,0,1,0,1,1
      for (int i = 0; i < 7; i++) begin
         Out_ready  = pat[i];
         Load_valid = (i % 2) == 1;
         Tile_in    = ~t;
         tick();
      end
      Load_valid = 1'b0; Out_ready = 1'b1;
      tick();
      check("t2_beats", log_data.size(), 4);
      check("t2_idle", Load_ready, 1'b1);
      if (log_data.size() == 4)
         for (int k = 0; k < 4; k++)
            check("t2_data", log_data[k], t[ord_q[k]*16 +: 16]);

      // Abort together with the third handshake
      clear_log();
      Tile_in = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}; Load_valid = 1'b1;
      tick();
      Load_valid = 1'b0;
      tick(); tick();
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      check("t3_beats", log_data.size(), 2);
      check("t3_valid_after_abort", Out_valid, 1'b0);
      check("t3_ready_after_abort", Load_ready, 1'b1);
      clear_log();
      Tile_in = {16'hAAAD, 16'hAAAC, 16'hAAAB, 16'hAAAA}; Load_valid = 1'b1;
      tick();
      Load_valid = 1'b0;
      check("t3_new_idx0", Out_idx, 2'd0);
      check("t3_new_data0", Out_data, 16'hAAAA);
      repeat (5) tick();
      check("t3_new_beats", log_data.size(), 4);

      // Asynchronous reset during beat 1
      Tile_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111}; Load_valid = 1'b1;
      tick();
      Load_valid = 1'b0;
      tick();
      #2 Rst = 1'b1;
      #1;
      check("t4_valid_in_rst", Out_valid, 1'b0);
      check("t4_data_in_rst", Out_data, 16'h0);
      check("t4_idx_in_rst", Out_idx, 2'd0);
      tick();
      Rst = 1'b0;
      #1;
      check("t4_ready_after_rst", Load_ready, 1'b1);
      clear_log();
      Tile_in = {16'h8888, 16'h7777, 16'h6666, 16'h5555}; Load_valid = 1'b1;
      tick();
      Load_valid = 1'b0;
      repeat (5) tick();
      check("t4_beats", log_data.size(), 4);
      if (log_data.size() == 4) begin
         check("t4_first_data", log_data[0], 16'h5555);
         check("t4_first_idx", log_idx[0], 0);
      end

      // Back-to-back tiles with Load_valid held high
      clear_log();
      Tile_in = {16'hA004, 16'hA003, 16'hA002, 16'hA001}; Load_valid = 1'b1;
      tick();
      Tile_in = {16'hB004, 16'hB003, 16'hB002, 16'hB001};
      repeat (8) tick();
      Load_valid = 1'b0;
      repeat (12) tick();
      check("t5_beats_ge8", log_data.size() >= 8, 1'b1);
      if (log_data.size() >= 8) begin
         check("t5_a_last", log_last[3], 1'b1);
         check("t5_gap", log_cyc[4] - log_cyc[3], 2);
         check("t5_b_first", log_data[4], 16'hB001);
         check("t5_b_idx", log_idx[4], 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
